// File: rtl/muldiv_pkg.sv
// Shared encodings and default widths for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/iterative_muldiv_if.sv
// Request/response bundle between decode, the register file ports and the muldiv unit.
interface iterative_muldiv_if #(
  parameter int WIDTH  = muldiv_pkg::DEFAULT_WIDTH,
  parameter int ADDR_W = muldiv_pkg::DEFAULT_ADDR_W
);
  import muldiv_pkg::*;

  logic                     in_Start;
  op_e                      in_Op;
  logic signed [WIDTH-1:0]  in_OperandA;
  logic signed [WIDTH-1:0]  in_OperandB;
  logic [ADDR_W-1:0]        in_DestAddr;
  logic                     out_Busy;
  logic                     out_Done;
  logic signed [WIDTH-1:0]  out_Result;
  logic                     out_RegWrite;
  logic [ADDR_W-1:0]        out_WriteAddr;

  modport master (
    output in_Start, in_Op, in_OperandA, in_OperandB, in_DestAddr,
    input  out_Busy, out_Done, out_Result, out_RegWrite, out_WriteAddr
  );

  modport slave (
    input  in_Start, in_Op, in_OperandA, in_OperandB, in_DestAddr,
    output out_Busy, out_Done, out_Result, out_RegWrite, out_WriteAddr
  );

endinterface

// File: rtl/muldiv_step.sv
// One unsigned iteration on the shared accumulator: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH:0]     acc_i,
  input  logic [WIDTH:0]       opnd_i,
  output logic [2*WIDTH:0]     acc_o
);

  localparam int AW = 2*WIDTH + 1;

  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_next;

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum      = {1'b0, acc_i[AW-1:WIDTH]} + {1'b0, opnd_i};
    shifted  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff     = {1'b0, shifted} - {1'b0, opnd_i};
    rem_next = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
    acc_o    = '0;
    if (is_div) begin
      acc_o = {rem_next, acc_i[WIDTH-2:0], ~diff[WIDTH+1]};
    end else if (acc_i[0]) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[AW-1:1]};
    end
  end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle signed MUL/MULH/DIV/REM unit: sign-magnitude iteration with a final sign fix-up,
// result returned through the register file write port.
module iterative_muldiv #(
  parameter int WIDTH  = muldiv_pkg::DEFAULT_WIDTH,
  parameter int ADDR_W = muldiv_pkg::DEFAULT_ADDR_W,
  parameter int ITERS  = muldiv_pkg::DEFAULT_WIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  iterative_muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam int AW = 2*WIDTH + 1;
  localparam int CW = $clog2(ITERS);

  state_e                  state_q, state_d;
  op_e                     op_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [ADDR_W-1:0]       dest_q;
  logic [WIDTH:0]          mag_a_q, mag_b_q;
  logic [WIDTH:0]          mag_a_d, mag_b_d;
  logic                    sign_q;
  logic                    div0_q;
  logic [CW-1:0]           cnt_q;
  logic [AW-1:0]           acc_q, acc_step;
  logic [WIDTH:0]          step_opnd;
  logic                    is_div;
  logic                    div_by_zero;
  logic [WIDTH-1:0]        fix_result;
  logic [2*WIDTH-1:0]      prod_signed;
  logic [WIDTH-1:0]        quo_signed, rem_signed;
  logic signed [WIDTH-1:0] result_q;
  logic [ADDR_W-1:0]       waddr_q;

  // |v| needs one extra bit so that the most negative operand has a representable magnitude.
  function automatic logic [WIDTH:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return ext[WIDTH] ? -ext : ext;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_div      = (op_q == OP_DIV) || (op_q == OP_REM);
  assign div_by_zero = is_div && (b_q == '0);
  assign mag_a_d     = magnitude(a_q);
  assign mag_b_d     = magnitude(b_q);
  assign step_opnd   = is_div ? mag_b_q : mag_a_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_i  (acc_q),
    .opnd_i (step_opnd),
    .acc_o  (acc_step)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divide-by-zero passes through FIX so its special value lands in the same result register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_Start) state_d = SETUP;
      SETUP:   state_d = div_by_zero ? FIX : ITER;
      ITER:    if (cnt_q == CW'(ITERS-1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_signed = apply_sign_wide(acc_q[2*WIDTH-1:0], sign_q);
    quo_signed  = apply_sign(acc_q[WIDTH-1:0], sign_q);
    rem_signed  = apply_sign(acc_q[2*WIDTH-1:WIDTH], sign_q);
    fix_result  = '0;
    if (div0_q) begin
      fix_result = (op_q == OP_DIV) ? '1 : a_q;
    end else begin
      case (op_q)
        OP_MUL:  fix_result = prod_signed[WIDTH-1:0];
        OP_MULH: fix_result = prod_signed[2*WIDTH-1:WIDTH];
        OP_DIV:  fix_result = quo_signed;
        default: fix_result = rem_signed;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      dest_q   <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sign_q   <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_Start) begin
            op_q   <= bus.in_Op;
            a_q    <= bus.in_OperandA;
            b_q    <= bus.in_OperandB;
            dest_q <= bus.in_DestAddr;
          end
        end
        SETUP: begin
          mag_a_q <= mag_a_d;
          mag_b_q <= mag_b_d;
          sign_q  <= (op_q == OP_REM) ? a_q[WIDTH-1] : (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          div0_q  <= div_by_zero;
          cnt_q   <= '0;
          acc_q   <= {{(WIDTH+1){1'b0}}, is_div ? mag_a_d[WIDTH-1:0] : mag_b_d[WIDTH-1:0]};
        end
        ITER: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          result_q <= fix_result;
          waddr_q  <= dest_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_Busy      = (state_q != IDLE);
  assign bus.out_Done      = (state_q == DONE);
  assign bus.out_RegWrite  = (state_q == DONE) && (waddr_q != '0);
  assign bus.out_Result    = result_q;
  assign bus.out_WriteAddr = waddr_q;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv: directed corner cases plus random operations.
module tb_iterative_muldiv;
  import muldiv_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  iterative_muldiv_if #(.WIDTH(16), .ADDR_W(4)) bus ();

  iterative_muldiv #(.WIDTH(16), .ADDR_W(4), .ITERS(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct {
    logic signed [15:0] res;
    logic [3:0]         addr;
    logic               wr;
    int                 lat;
    int                 start_edge;
    string              tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain 32-bit integer arithmetic, truncating division, dividend-signed remainder.
  function automatic logic [15:0] ref_model(input op_e op, input int a, input int b);
    int r;
    r = 0;
    case (op)
      OP_MUL:  begin r = a * b; return r[15:0]; end
      OP_MULH: begin r = a * b; return r[31:16]; end
      OP_DIV:  begin if (b == 0) return 16'hFFFF; r = a / b; return r[15:0]; end
      default: begin if (b == 0) return a[15:0]; r = a % b; return r[15:0]; end
    endcase
  endfunction

  function automatic logic [15:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      4: return 16'h8000;
      default: return r[15:0];
    endcase
  endfunction

  // Monitor: every completion is matched against the oldest outstanding request.
  always @(negedge CLK) begin
    if (RST) begin
      if (sb.size() > 0) chk("busy_inflight", 32'(bus.out_Busy), 32'd1);
      if (bus.out_Done) begin
        chk("done_single_pulse", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.tag, "_result"},   32'(bus.out_Result),    32'(mon_e.res));
          chk({mon_e.tag, "_regwrite"}, 32'(bus.out_RegWrite),  32'(mon_e.wr));
          chk({mon_e.tag, "_waddr"},    32'(bus.out_WriteAddr), 32'(mon_e.addr));
          chk({mon_e.tag, "_latency"},  32'(cyc - mon_e.start_edge), 32'(mon_e.lat));
        end
      end else begin
        chk("regwrite_without_done", 32'(bus.out_RegWrite), 32'd0);
      end
    end
    prev_done = bus.out_Done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (bus.out_Busy && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (bus.out_Busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=1 expected=0");
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.out_Done && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.out_Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout done=0 expected=1");
    end
  endtask

  task automatic issue(input op_e op, input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic [3:0] dest, input string tag);
    exp_t e;
    wait_idle();
    bus.in_Op       = op;
    bus.in_OperandA = a;
    bus.in_OperandB = b;
    bus.in_DestAddr = dest;
    bus.in_Start    = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_Start = 1'b0;
    e.res        = ref_model(op, int'(a), int'(b));
    e.addr       = dest;
    e.wr         = (dest != 4'd0);
    e.lat        = ((op == OP_DIV || op == OP_REM) && b == 16'sd0) ? 2 : 18;
    e.start_edge = cyc;
    e.tag        = tag;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     32'(bus.out_Busy),      32'd0);
    chk({tag, "_done"},     32'(bus.out_Done),      32'd0);
    chk({tag, "_regwrite"}, 32'(bus.out_RegWrite),  32'd0);
    chk({tag, "_result"},   32'(bus.out_Result),    32'd0);
    chk({tag, "_waddr"},    32'(bus.out_WriteAddr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_Start    = 1'b0;
    bus.in_Op       = OP_MUL;
    bus.in_OperandA = '0;
    bus.in_OperandB = '0;
    bus.in_DestAddr = '0;
    RST             = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    RST = 1'b1;

    issue(OP_MUL,  16'sd7,    -16'sd3,  4'd5, "mul_7x-3");
    issue(OP_MULH, 16'h4000,  16'h0010, 4'd2, "mulh_hi");
    issue(OP_MUL,  16'h4000,  16'h0010, 4'd3, "mul_lo_trunc");
    issue(OP_DIV,  -16'sd17,  16'sd5,   4'd1, "div_-17_5");
    issue(OP_REM,  -16'sd17,  16'sd5,   4'd4, "rem_-17_5");
    issue(OP_DIV,  16'sd100,  16'sd0,   4'd6, "div_by0");
    issue(OP_REM,  16'sd100,  16'sd0,   4'd7, "rem_by0");
    issue(OP_DIV,  16'h8000,  -16'sd1,  4'd8, "div_ovf");
    issue(OP_REM,  16'h8000,  -16'sd1,  4'd9, "rem_ovf");
    issue(OP_MULH, 16'h8000,  16'h8000, 4'd10, "mulh_minmin");
    issue(OP_MUL,  16'sd9,    16'sd9,   4'd0, "mul_dest0");

    // Start pulses while iterating and while in DONE must not launch new operations.
    issue(OP_MULH, -16'sd1234, 16'sd567, 4'd11, "mulh_ignored_starts");
    repeat (6) @(negedge CLK);
    bus.in_Op = OP_DIV; bus.in_OperandA = 16'sd1; bus.in_OperandB = 16'sd1;
    bus.in_Start = 1'b1;
    @(negedge CLK);
    bus.in_Start = 1'b0;
    wait_done();
    bus.in_Start = 1'b1;
    @(negedge CLK);
    bus.in_Start = 1'b0;

    // Reset sampled eight edges after the start edge aborts the operation.
    issue(OP_MUL, 16'h1234, 16'h0567, 4'd12, "aborted");
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    @(negedge CLK);
    check_reset_outputs("midop_reset");
    RST = 1'b1;
    issue(OP_MUL, 16'sd3, 16'sd4, 4'd13, "post_reset_mul");

    for (int i = 0; i < 150; i++) begin
      logic [1:0] opb;
      opb = 2'($urandom_range(0, 3));
      issue(op_e'(opb), pick(), pick(), 4'($urandom_range(0, 15)), "rand");
    end

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
    end
    repeat (25) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
